// File: rtl/wav_dfi_phy_hs_responder.sv
// wav_dfi_phy_hs_responder
// PHY-side endpoint of the DFI control handshakes driven by the memory controller.
// It acknowledges lp_ctrl/lp_data low-power requests and ctrlupd requests, and it
// raises phyupd requests when the PHY update engine triggers one.
//
// Ports
//   clock, reset              DFI clock, synchronous active-high reset
//   init_start                DFI init in progress; no new handshake is accepted
//   lp_accept_en              CSR enable for acknowledging low-power requests
//   lp_ctrl_req/_wakeup/_ack  control low-power handshake
//   lp_data_req/_wakeup/_ack  data low-power handshake
//   lp_*_wakeup_q             wakeup value captured when the matching ack rises
//   ctrlupd_req/_ack          MC-initiated update handshake
//   upd_start, upd_type       PHY update engine trigger and update type
//   phyupd_req/_type/_ack     PHY-initiated update handshake
//   phyupd_timeout            1-cycle pulse when the MC never acks a phyupd
//   busy                      main handshake FSM is not idle
// All outputs are registered.
module wav_dfi_phy_hs_responder #(
  parameter int LP_ACK_LAT   = 2,
  parameter int CTRLUPD_LAT  = 2,
  parameter int TPHYUPD_RESP = 32,
  parameter int PHYUPD_HOLD  = 16,
  parameter int CW           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init_start,
  input  logic       lp_accept_en,
  input  logic       lp_ctrl_req,
  input  logic [5:0] lp_ctrl_wakeup,
  output logic       lp_ctrl_ack,
  input  logic       lp_data_req,
  input  logic [5:0] lp_data_wakeup,
  output logic       lp_data_ack,
  output logic [5:0] lp_ctrl_wakeup_q,
  output logic [5:0] lp_data_wakeup_q,
  input  logic       ctrlupd_req,
  output logic       ctrlupd_ack,
  input  logic       upd_start,
  input  logic [1:0] upd_type,
  output logic       phyupd_req,
  output logic [1:0] phyupd_type,
  input  logic       phyupd_ack,
  output logic       phyupd_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {LP_IDLE, LP_CNT, LP_ACK} lp_state_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CU_CNT, ST_CU_ACK, ST_PU_REQ, ST_PU_HOLD, ST_PU_REL
  } st_e;

  // Counters compare against "last count" values so the compare never needs CW+1 bits.
  localparam logic [CW-1:0] LP_LAST   = CW'(LP_ACK_LAT - 1);
  localparam logic [CW-1:0] CU_LAST   = CW'(CTRLUPD_LAT - 1);
  localparam logic [CW-1:0] RESP_LAST = CW'(TPHYUPD_RESP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(PHYUPD_HOLD - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Index 0 = lp_ctrl, index 1 = lp_data; both channels run the same independent FSM.
  logic [1:0] lp_req;
  logic [5:0] lp_wk [2];
  assign lp_req   = {lp_data_req, lp_ctrl_req};
  assign lp_wk[0] = lp_ctrl_wakeup;
  assign lp_wk[1] = lp_data_wakeup;

  lp_state_e     lp_state_q [2];
  lp_state_e     lp_state_d [2];
  logic [CW-1:0] lp_cnt_q [2];
  logic [CW-1:0] lp_cnt_d [2];
  logic [5:0]    lp_wk_q [2];
  logic [5:0]    lp_wk_d [2];
  logic [1:0]    lp_ack_q, lp_ack_d;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cu_ack_q, cu_ack_d;
  logic          pu_req_q, pu_req_d;
  logic [1:0]    pu_type_q, pu_type_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lp_state_d[i] = lp_state_q[i];
      lp_cnt_d[i]   = lp_cnt_q[i];
      lp_wk_d[i]    = lp_wk_q[i];
      lp_ack_d[i]   = lp_ack_q[i];
      case (lp_state_q[i])
        LP_IDLE: begin
          if (lp_req[i] && lp_accept_en && !init_start) begin
            // The accepting cycle already counts as the first stable req cycle.
            if (LP_ACK_LAT <= 1) begin
              lp_state_d[i] = LP_ACK;
              lp_ack_d[i]   = 1'b1;
              lp_wk_d[i]    = lp_wk[i];
            end else begin
              lp_state_d[i] = LP_CNT;
              lp_cnt_d[i]   = CW'(1);
            end
          end
        end
        LP_CNT: begin
          if (!lp_req[i]) begin
            lp_state_d[i] = LP_IDLE;
            lp_cnt_d[i]   = '0;
          end else if (lp_cnt_q[i] >= LP_LAST) begin
            lp_state_d[i] = LP_ACK;
            lp_cnt_d[i]   = '0;
            lp_ack_d[i]   = 1'b1;
            lp_wk_d[i]    = lp_wk[i];
          end else begin
            lp_cnt_d[i] = sat_inc(lp_cnt_q[i]);
          end
        end
        LP_ACK: begin
          // lp_accept_en is deliberately ignored here: an ack already given is held.
          if (!lp_req[i]) begin
            lp_state_d[i] = LP_IDLE;
            lp_ack_d[i]   = 1'b0;
          end
        end
        default: begin
          lp_state_d[i] = LP_IDLE;
          lp_cnt_d[i]   = '0;
          lp_ack_d[i]   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    cu_ack_d  = cu_ack_q;
    pu_req_d  = pu_req_q;
    pu_type_d = pu_type_q;
    timeout_d = 1'b0;
    case (st_q)
      ST_IDLE: begin
        // ctrlupd has priority; a simultaneous upd_start is dropped, not queued.
        if (!init_start) begin
          if (ctrlupd_req) begin
            if (CTRLUPD_LAT <= 1) begin
              st_d     = ST_CU_ACK;
              cu_ack_d = 1'b1;
            end else begin
              st_d  = ST_CU_CNT;
              cnt_d = CW'(1);
            end
          end else if (upd_start) begin
            st_d      = ST_PU_REQ;
            cnt_d     = '0;
            pu_req_d  = 1'b1;
            pu_type_d = upd_type;
          end
        end
      end
      ST_CU_CNT: begin
        if (!ctrlupd_req) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else if (cnt_q >= CU_LAST) begin
          st_d     = ST_CU_ACK;
          cnt_d    = '0;
          cu_ack_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_CU_ACK: begin
        if (!ctrlupd_req) begin
          st_d     = ST_IDLE;
          cu_ack_d = 1'b0;
        end
      end
      ST_PU_REQ: begin
        // An ack on the final waiting cycle still wins over the timeout.
        if (phyupd_ack) begin
          st_d  = ST_PU_HOLD;
          cnt_d = '0;
        end else if (cnt_q >= RESP_LAST) begin
          st_d      = ST_IDLE;
          cnt_d     = '0;
          pu_req_d  = 1'b0;
          pu_type_d = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PU_HOLD: begin
        if (cnt_q >= HOLD_LAST) begin
          st_d      = ST_PU_REL;
          cnt_d     = '0;
          pu_req_d  = 1'b0;
          pu_type_d = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PU_REL: begin
        if (!phyupd_ack) st_d = ST_IDLE;
      end
      default: begin
        st_d      = ST_IDLE;
        cnt_d     = '0;
        cu_ack_d  = 1'b0;
        pu_req_d  = 1'b0;
        pu_type_d = '0;
      end
    endcase
    busy_d = (st_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        lp_state_q[i] <= LP_IDLE;
        lp_cnt_q[i]   <= '0;
        lp_wk_q[i]    <= '0;
      end
      lp_ack_q  <= '0;
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      cu_ack_q  <= 1'b0;
      pu_req_q  <= 1'b0;
      pu_type_q <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        lp_state_q[i] <= lp_state_d[i];
        lp_cnt_q[i]   <= lp_cnt_d[i];
        lp_wk_q[i]    <= lp_wk_d[i];
      end
      lp_ack_q  <= lp_ack_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      cu_ack_q  <= cu_ack_d;
      pu_req_q  <= pu_req_d;
      pu_type_q <= pu_type_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign lp_ctrl_ack      = lp_ack_q[0];
  assign lp_data_ack      = lp_ack_q[1];
  assign lp_ctrl_wakeup_q = lp_wk_q[0];
  assign lp_data_wakeup_q = lp_wk_q[1];
  assign ctrlupd_ack      = cu_ack_q;
  assign phyupd_req       = pu_req_q;
  assign phyupd_type      = pu_type_q;
  assign phyupd_timeout   = timeout_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_wav_dfi_phy_hs_responder.sv
`timescale 1ns/1ps
module tb_wav_dfi_phy_hs_responder;
  localparam int LP_ACK_LAT   = 2;
  localparam int CTRLUPD_LAT  = 2;
  localparam int TPHYUPD_RESP = 32;
  localparam int PHYUPD_HOLD  = 16;
  localparam int CW           = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       init_start = 1'b0;
  logic       lp_accept_en = 1'b0;
  logic       lp_ctrl_req = 1'b0;
  logic [5:0] lp_ctrl_wakeup = '0;
  logic       lp_ctrl_ack;
  logic       lp_data_req = 1'b0;
  logic [5:0] lp_data_wakeup = '0;
  logic       lp_data_ack;
  logic [5:0] lp_ctrl_wakeup_q;
  logic [5:0] lp_data_wakeup_q;
  logic       ctrlupd_req = 1'b0;
  logic       ctrlupd_ack;
  logic       upd_start = 1'b0;
  logic [1:0] upd_type = '0;
  logic       phyupd_req;
  logic [1:0] phyupd_type;
  logic       phyupd_ack = 1'b0;
  logic       phyupd_timeout;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  wav_dfi_phy_hs_responder #(
    .LP_ACK_LAT(LP_ACK_LAT), .CTRLUPD_LAT(CTRLUPD_LAT), .TPHYUPD_RESP(TPHYUPD_RESP),
    .PHYUPD_HOLD(PHYUPD_HOLD), .CW(CW)
  ) dut (
    .clock(clock), .reset(reset), .init_start(init_start), .lp_accept_en(lp_accept_en),
    .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_wakeup(lp_ctrl_wakeup), .lp_ctrl_ack(lp_ctrl_ack),
    .lp_data_req(lp_data_req), .lp_data_wakeup(lp_data_wakeup), .lp_data_ack(lp_data_ack),
    .lp_ctrl_wakeup_q(lp_ctrl_wakeup_q), .lp_data_wakeup_q(lp_data_wakeup_q),
    .ctrlupd_req(ctrlupd_req), .ctrlupd_ack(ctrlupd_ack),
    .upd_start(upd_start), .upd_type(upd_type),
    .phyupd_req(phyupd_req), .phyupd_type(phyupd_type), .phyupd_ack(phyupd_ack),
    .phyupd_timeout(phyupd_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Reference model. Low-power and ctrlupd handshakes are described by the length
  // of the current run of accepted req cycles (0 = not engaged); the ack is simply
  // "run length has reached the latency". phyupd is described as a phase number
  // plus the age of the request inside that phase.
  int         lp_run [2];
  bit         m_lp_ack [2];
  logic [5:0] m_wk [2];
  int         m_mode;   // 0 none, 1 ctrlupd, 2 phyupd waiting, 3 phyupd holding, 4 phyupd releasing
  int         cu_run;
  int         m_age;
  logic [1:0] m_type;
  bit         m_timeout;

  initial begin
    for (int i = 0; i < 2; i++) begin lp_run[i] = 0; m_lp_ack[i] = 0; m_wk[i] = '0; end
    m_mode = 0; cu_run = 0; m_age = 0; m_type = '0; m_timeout = 0;
  end

  always @(posedge clock) begin
    bit         rq [2];
    logic [5:0] wk [2];
    bit         na;
    rq[0] = lp_ctrl_req; rq[1] = lp_data_req;
    wk[0] = lp_ctrl_wakeup; wk[1] = lp_data_wakeup;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin lp_run[i] = 0; m_lp_ack[i] = 0; m_wk[i] = '0; end
      m_mode = 0; cu_run = 0; m_age = 0; m_type = '0; m_timeout = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (lp_run[i] == 0) lp_run[i] = (rq[i] && lp_accept_en && !init_start) ? 1 : 0;
        else if (rq[i]) lp_run[i] = (lp_run[i] < 1000) ? lp_run[i] + 1 : lp_run[i];
        else lp_run[i] = 0;
        na = (lp_run[i] >= LP_ACK_LAT);
        if (na && !m_lp_ack[i]) m_wk[i] = wk[i];
        m_lp_ack[i] = na;
      end
      m_timeout = 0;
      case (m_mode)
        0: if (!init_start) begin
          if (ctrlupd_req) begin m_mode = 1; cu_run = 1; end
          else if (upd_start) begin m_mode = 2; m_age = 0; m_type = upd_type; end
        end
        1: if (ctrlupd_req) cu_run = (cu_run < 1000) ? cu_run + 1 : cu_run;
           else begin m_mode = 0; cu_run = 0; end
        2: begin
          m_age++;
          if (phyupd_ack) begin m_mode = 3; m_age = 0; end
          else if (m_age >= TPHYUPD_RESP) begin m_mode = 0; m_timeout = 1; end
        end
        3: begin m_age++; if (m_age >= PHYUPD_HOLD) m_mode = 4; end
        default: if (!phyupd_ack) m_mode = 0;
      endcase
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      bit pr;
      pr = (m_mode == 2 || m_mode == 3);
      chk("lp_ctrl_ack", 8'(lp_ctrl_ack), 8'(m_lp_ack[0]));
      chk("lp_data_ack", 8'(lp_data_ack), 8'(m_lp_ack[1]));
      chk("lp_ctrl_wakeup_q", 8'(lp_ctrl_wakeup_q), 8'(m_wk[0]));
      chk("lp_data_wakeup_q", 8'(lp_data_wakeup_q), 8'(m_wk[1]));
      chk("ctrlupd_ack", 8'(ctrlupd_ack), 8'(m_mode == 1 && cu_run >= CTRLUPD_LAT));
      chk("phyupd_req", 8'(phyupd_req), 8'(pr));
      chk("phyupd_type", 8'(phyupd_type), pr ? 8'(m_type) : 8'h0);
      chk("phyupd_timeout", 8'(phyupd_timeout), 8'(m_timeout));
      chk("busy", 8'(busy), 8'(m_mode != 0));
      if (ctrlupd_ack && phyupd_req) chk("cu_pu_exclusive", 8'h1, 8'h0);
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    tick(); tick();
    chk("reset_busy", 8'(busy), 8'h0);
    chk("reset_lp_ctrl_ack", 8'(lp_ctrl_ack), 8'h0);
    chk("reset_phyupd_req", 8'(phyupd_req), 8'h0);
    cmp_en = 1'b1;
    reset = 1'b0;
    tick();

    // lp_ctrl request with wakeup 0x0A held 10 cycles
    lp_accept_en = 1'b1; lp_ctrl_req = 1'b1; lp_ctrl_wakeup = 6'h0A;
    tick();
    chk("lp1_ack_cycle1", 8'(lp_ctrl_ack), 8'h0);
    tick();
    chk("lp1_ack_cycle2", 8'(lp_ctrl_ack), 8'h1);
    chk("lp1_wakeup_q", 8'(lp_ctrl_wakeup_q), 8'h0A);
    chk("model_lp1_ack", 8'(m_lp_ack[0]), 8'h1);
    lp_ctrl_wakeup = 6'h15;
    lp_accept_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("lp1_ack_held", 8'(lp_ctrl_ack), 8'h1);
    chk("lp1_wakeup_frozen", 8'(lp_ctrl_wakeup_q), 8'h0A);
    lp_ctrl_req = 1'b0;
    tick();
    chk("lp1_ack_drop", 8'(lp_ctrl_ack), 8'h0);
    tick();

    // lp_data request while acceptance is disabled
    lp_accept_en = 1'b0; lp_data_req = 1'b1; lp_data_wakeup = 6'h33;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lp2_no_ack", 8'(lp_data_ack), 8'h0);
    end
    lp_data_req = 1'b0;
    tick(); tick();

    // ctrlupd and upd_start in the same cycle
    ctrlupd_req = 1'b1; upd_start = 1'b1; upd_type = 2'd3;
    tick();
    upd_start = 1'b0;
    chk("cu_ack_cycle1", 8'(ctrlupd_ack), 8'h0);
    tick();
    chk("cu_ack_cycle2", 8'(ctrlupd_ack), 8'h1);
    chk("cu_pu_dropped", 8'(phyupd_req), 8'h0);
    chk("model_cu_mode", 8'(m_mode), 8'h1);
    tick(); tick();
    ctrlupd_req = 1'b0;
    tick();
    chk("cu_ack_drop", 8'(ctrlupd_ack), 8'h0);
    chk("cu_busy_clear", 8'(busy), 8'h0);
    chk("cu_no_late_pu", 8'(phyupd_req), 8'h0);
    tick();

    // phyupd with type 2, acked on cycle 5
    upd_start = 1'b1; upd_type = 2'd2;
    tick();
    upd_start = 1'b0; upd_type = 2'd0;
    chk("pu_req_rise", 8'(phyupd_req), 8'h1);
    chk("pu_type", 8'(phyupd_type), 8'h2);
    for (int i = 0; i < 4; i++) tick();
    phyupd_ack = 1'b1;
    for (int i = 0; i < PHYUPD_HOLD; i++) begin
      tick();
      chk("pu_hold_req", 8'(phyupd_req), 8'h1);
      chk("pu_hold_type", 8'(phyupd_type), 8'h2);
    end
    tick();
    chk("pu_rel_req", 8'(phyupd_req), 8'h0);
    chk("pu_rel_type", 8'(phyupd_type), 8'h0);
    chk("pu_rel_busy", 8'(busy), 8'h1);
    chk("model_pu_rel", 8'(m_mode), 8'h4);
    phyupd_ack = 1'b0;
    tick();
    chk("pu_idle_busy", 8'(busy), 8'h0);
    tick();

    // phyupd never acknowledged
    upd_start = 1'b1; upd_type = 2'd1;
    tick();
    upd_start = 1'b0;
    n = 1;
    while (phyupd_req && n < 100) begin
      tick();
      if (phyupd_req) n++;
    end
    chk("to_req_len", 8'(n), 8'(TPHYUPD_RESP));
    chk("to_pulse", 8'(phyupd_timeout), 8'h1);
    chk("to_busy", 8'(busy), 8'h0);
    tick();
    chk("to_pulse_end", 8'(phyupd_timeout), 8'h0);

    // reset during PU_HOLD and LP ACK, then init_start blocking
    lp_accept_en = 1'b1; lp_ctrl_req = 1'b1; lp_ctrl_wakeup = 6'h2B;
    upd_start = 1'b1; upd_type = 2'd1;
    tick();
    upd_start = 1'b0;
    tick();
    phyupd_ack = 1'b1;
    tick(); tick();
    chk("rst_pre_lp_ack", 8'(lp_ctrl_ack), 8'h1);
    chk("rst_pre_pu_req", 8'(phyupd_req), 8'h1);
    chk("rst_pre_wk", 8'(lp_ctrl_wakeup_q), 8'h2B);
    reset = 1'b1;
    tick();
    chk("rst_lp_ack", 8'(lp_ctrl_ack), 8'h0);
    chk("rst_wk", 8'(lp_ctrl_wakeup_q), 8'h0);
    chk("rst_pu_req", 8'(phyupd_req), 8'h0);
    chk("rst_pu_type", 8'(phyupd_type), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    reset = 1'b0; lp_ctrl_req = 1'b0; phyupd_ack = 1'b0;
    tick();
    init_start = 1'b1; ctrlupd_req = 1'b1; upd_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("init_cu_blocked", 8'(ctrlupd_ack), 8'h0);
      chk("init_pu_blocked", 8'(phyupd_req), 8'h0);
      chk("init_busy", 8'(busy), 8'h0);
    end
    init_start = 1'b0; ctrlupd_req = 1'b0; upd_start = 1'b0;
    tick(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset          = ($urandom_range(0, 299) == 0);
      init_start     = ($urandom_range(0, 15) == 0);
      lp_accept_en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) lp_ctrl_req = ~lp_ctrl_req;
      if ($urandom_range(0, 5) == 0) lp_data_req = ~lp_data_req;
      lp_ctrl_wakeup = 6'($urandom);
      lp_data_wakeup = 6'($urandom);
      if ($urandom_range(0, 11) == 0) ctrlupd_req = ~ctrlupd_req;
      upd_start      = ($urandom_range(0, 7) == 0);
      upd_type       = 2'($urandom);
      if (phyupd_req && $urandom_range(0, 19) == 0) phyupd_ack = 1'b1;
      else if (!phyupd_req && $urandom_range(0, 2) == 0) phyupd_ack = 1'b0;
    end
    reset = 1'b0; init_start = 1'b0; lp_ctrl_req = 1'b0; lp_data_req = 1'b0;
    ctrlupd_req = 1'b0; upd_start = 1'b0; phyupd_ack = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
